// File: rtl/morse_round_ctrl_if.sv
// Bundle between the Morse decoder/control buttons and the round sequencer.
// master: drives the game pulses and observes status; slave: the sequencer.
//   start, ld_dot, ld_line, done_input, next_input : one-cycle input pulses
//   decoder_clear                                  : decoder clear pulse
//   p1_active, p2_active, p1_value, p2_value       : entry phase and codes
//   symbol_count, result_valid, match              : entry progress, result
//   p1_score, p2_score, round, game_over           : game status
interface morse_round_ctrl_if #(
    parameter int unsigned MAX_SYMBOLS = 5
);
    localparam int unsigned CW = 2 * MAX_SYMBOLS;

    logic          start;
    logic          ld_dot;
    logic          ld_line;
    logic          done_input;
    logic          next_input;
    logic          decoder_clear;
    logic          p1_active;
    logic          p2_active;
    logic [CW-1:0] p1_value;
    logic [CW-1:0] p2_value;
    logic [2:0]    symbol_count;
    logic          result_valid;
    logic          match;
    logic [3:0]    p1_score;
    logic [3:0]    p2_score;
    logic [3:0]    round;
    logic          game_over;

    modport master (
        output start, ld_dot, ld_line, done_input, next_input,
        input  decoder_clear, p1_active, p2_active, p1_value, p2_value,
               symbol_count, result_valid, match, p1_score, p2_score,
               round, game_over
    );

    modport slave (
        input  start, ld_dot, ld_line, done_input, next_input,
        output decoder_clear, p1_active, p2_active, p1_value, p2_value,
               symbol_count, result_valid, match, p1_score, p2_score,
               round, game_over
    );
endinterface

// File: rtl/morse_round_ctrl.sv
// Round sequencer for the two-player Morse game: routes decoder symbols into
// player 1 then player 2 codes, compares them, scores, and counts rounds.
// Ports: clock, resetn (synchronous, active-low), bus (morse_round_ctrl_if.slave).
// All bus outputs are registered.
module morse_round_ctrl #(
    parameter int unsigned MAX_SYMBOLS = 5,
    parameter int unsigned ROUNDS      = 8
) (
    input  logic              clock,
    input  logic              resetn,
    morse_round_ctrl_if.slave bus
);
    localparam int unsigned CW = 2 * MAX_SYMBOLS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P1_ENTRY  = 3'd1,
        P2_ENTRY  = 3'd2,
        COMPARE   = 3'd3,
        RESULT    = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] p1_value_q, p1_value_d;
    logic [CW-1:0] p2_value_q, p2_value_d;
    logic [2:0]    count_q, count_d;
    logic [3:0]    p1_score_q, p1_score_d;
    logic [3:0]    p2_score_q, p2_score_d;
    logic [3:0]    round_q, round_d;
    logic          match_q, match_d;
    logic          clear_q, clear_d;
    logic          p1_act_q, p1_act_d;
    logic          p2_act_q, p2_act_d;
    logic          rvalid_q, rvalid_d;
    logic          over_q, over_d;

    logic          sym_ok;
    logic [1:0]    sym_bits;
    logic [2:0]    count_inc;

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            p1_value_q <= '0;
            p2_value_q <= '0;
            count_q    <= '0;
            p1_score_q <= '0;
            p2_score_q <= '0;
            round_q    <= '0;
            match_q    <= 1'b0;
            clear_q    <= 1'b0;
            p1_act_q   <= 1'b0;
            p2_act_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_value_q <= p1_value_d;
            p2_value_q <= p2_value_d;
            count_q    <= count_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            round_q    <= round_d;
            match_q    <= match_d;
            clear_q    <= clear_d;
            p1_act_q   <= p1_act_d;
            p2_act_q   <= p2_act_d;
            rvalid_q   <= rvalid_d;
            over_q     <= over_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        p1_value_d = p1_value_q;
        p2_value_d = p2_value_q;
        count_d    = count_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        round_d    = round_q;
        match_d    = match_q;
        clear_d    = 1'b0;

        // Exactly one of dot/line, and room left in the code
        sym_ok    = (bus.ld_dot ^ bus.ld_line) && (count_q < 3'(MAX_SYMBOLS));
        sym_bits  = bus.ld_dot ? 2'b01 : 2'b11;
        // Count after this cycle's symbol, so done+symbol closes a fresh entry
        count_inc = count_q + 3'(sym_ok);

        case (state_q)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    p1_value_d = '0;
                    p2_value_d = '0;
                    count_d    = '0;
                    p1_score_d = '0;
                    p2_score_d = '0;
                    round_d    = 4'd1;
                    clear_d    = 1'b1;
                    state_d    = P1_ENTRY;
                end
            end
            P1_ENTRY: begin
                if (sym_ok) begin
                    p1_value_d = {p1_value_q[CW-3:0], sym_bits};
                    count_d    = count_inc;
                end
                if (bus.done_input && (count_inc != 3'd0)) begin
                    count_d = '0;
                    clear_d = 1'b1;
                    state_d = P2_ENTRY;
                end
            end
            P2_ENTRY: begin
                if (sym_ok) begin
                    p2_value_d = {p2_value_q[CW-3:0], sym_bits};
                    count_d    = count_inc;
                end
                if (bus.done_input && (count_inc != 3'd0)) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                match_d = (p1_value_q == p2_value_q);
                if (p1_value_q == p2_value_q) begin
                    p2_score_d = p2_score_q + 4'd1;
                end else begin
                    p1_score_d = p1_score_q + 4'd1;
                end
                state_d = RESULT;
            end
            RESULT: begin
                if (bus.next_input) begin
                    if (round_q == 4'(ROUNDS)) begin
                        state_d = GAME_OVER;
                    end else begin
                        round_d    = round_q + 4'd1;
                        p1_value_d = '0;
                        p2_value_d = '0;
                        count_d    = '0;
                        clear_d    = 1'b1;
                        state_d    = P1_ENTRY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // State-decoded flags registered alongside the state
        p1_act_d = (state_d == P1_ENTRY);
        p2_act_d = (state_d == P2_ENTRY);
        rvalid_d = (state_d == RESULT);
        over_d   = (state_d == GAME_OVER);
    end

    assign bus.decoder_clear = clear_q;
    assign bus.p1_active     = p1_act_q;
    assign bus.p2_active     = p2_act_q;
    assign bus.p1_value      = p1_value_q;
    assign bus.p2_value      = p2_value_q;
    assign bus.symbol_count  = count_q;
    assign bus.result_valid  = rvalid_q;
    assign bus.match         = match_q;
    assign bus.p1_score      = p1_score_q;
    assign bus.p2_score      = p2_score_q;
    assign bus.round         = round_q;
    assign bus.game_over     = over_q;
endmodule

// File: tb/tb_morse_round_ctrl.sv
// Directed bench for morse_round_ctrl (MAX_SYMBOLS=5, ROUNDS=8).
module tb_morse_round_ctrl;
    logic clock = 1'b0;
    logic resetn;
    int   n_vec = 0;
    int   n_err = 0;

    morse_round_ctrl_if #(.MAX_SYMBOLS(5)) bus ();

    morse_round_ctrl #(.MAX_SYMBOLS(5), .ROUNDS(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input pulses, then sample 1 time unit after the edge
    task automatic cyc(input logic s, input logic d, input logic l,
                       input logic dn, input logic nx);
        bus.start      = s;
        bus.ld_dot     = d;
        bus.ld_line    = l;
        bus.done_input = dn;
        bus.next_input = nx;
        @(posedge clock);
        #1;
        bus.start      = 1'b0;
        bus.ld_dot     = 1'b0;
        bus.ld_line    = 1'b0;
        bus.done_input = 1'b0;
        bus.next_input = 1'b0;
    endtask

    // P1 enters one dot; P2 enters dot (same) or line; check result
    task automatic play_round(input logic same, input logic [3:0] rnd,
                              input logic [3:0] e_p1, input logic [3:0] e_p2);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, same, !same, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("compare_no_valid", 32'(bus.result_valid), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("rnd_valid", 32'(bus.result_valid), 32'd1);
        chk("rnd_match", 32'(bus.match), 32'(same));
        chk("rnd_p1_score", 32'(bus.p1_score), 32'(e_p1));
        chk("rnd_p2_score", 32'(bus.p2_score), 32'(e_p2));
        chk("rnd_round", 32'(bus.round), 32'(rnd));
    endtask

    initial begin
        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.ld_dot     = 1'b0;
        bus.ld_line    = 1'b0;
        bus.done_input = 1'b0;
        bus.next_input = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("rst_round", 32'(bus.round), 32'd0);
        chk("rst_p1_active", 32'(bus.p1_active), 32'd0);
        chk("rst_clear", 32'(bus.decoder_clear), 32'd0);
        chk("rst_valid", 32'(bus.result_valid), 32'd0);
        resetn = 1'b1;

        // Round 1: both enter dot,line -> match
        cyc(1, 0, 0, 0, 0);
        chk("start_round", 32'(bus.round), 32'd1);
        chk("start_p1_active", 32'(bus.p1_active), 32'd1);
        chk("start_clear", 32'(bus.decoder_clear), 32'd1);
        cyc(0, 0, 0, 1, 0);
        chk("done_empty_p1_active", 32'(bus.p1_active), 32'd1);
        chk("done_empty_clear", 32'(bus.decoder_clear), 32'd0);
        cyc(0, 1, 1, 0, 0);
        chk("both_count", 32'(bus.symbol_count), 32'd0);
        chk("both_value", 32'(bus.p1_value), 32'd0);
        cyc(0, 1, 0, 0, 0);
        chk("dot_value", 32'(bus.p1_value), 32'h001);
        chk("dot_count", 32'(bus.symbol_count), 32'd1);
        cyc(0, 0, 1, 0, 0);
        chk("line_value", 32'(bus.p1_value), 32'h007);
        cyc(0, 0, 0, 1, 0);
        chk("p1done_p2_active", 32'(bus.p2_active), 32'd1);
        chk("p1done_p1_active", 32'(bus.p1_active), 32'd0);
        chk("p1done_count", 32'(bus.symbol_count), 32'd0);
        chk("p1done_clear", 32'(bus.decoder_clear), 32'd1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("linedone_value", 32'(bus.p2_value), 32'h007);
        chk("linedone_count", 32'(bus.symbol_count), 32'd2);
        chk("linedone_p2_active", 32'(bus.p2_active), 32'd0);
        chk("linedone_valid", 32'(bus.result_valid), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("r1_valid", 32'(bus.result_valid), 32'd1);
        chk("r1_match", 32'(bus.match), 32'd1);
        chk("r1_p1_score", 32'(bus.p1_score), 32'd0);
        chk("r1_p2_score", 32'(bus.p2_score), 32'd1);
        cyc(0, 1, 0, 0, 0);
        chk("result_ignores_dot", 32'(bus.p1_value), 32'h007);
        cyc(0, 0, 0, 0, 1);
        chk("next_round", 32'(bus.round), 32'd2);
        chk("next_valid", 32'(bus.result_valid), 32'd0);
        chk("next_value", 32'(bus.p1_value), 32'd0);
        chk("next_clear", 32'(bus.decoder_clear), 32'd1);

        // Round 2: dot vs line -> mismatch
        play_round(1'b0, 4'd2, 4'd1, 4'd1);
        cyc(0, 0, 0, 0, 1);

        // Round 3: six dots each, sixth dropped -> match
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
        chk("sat_count", 32'(bus.symbol_count), 32'd5);
        chk("sat_value", 32'(bus.p1_value), 32'h155);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
        chk("sat_p2_value", 32'(bus.p2_value), 32'h155);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("r3_match", 32'(bus.match), 32'd1);
        chk("r3_p2_score", 32'(bus.p2_score), 32'd2);
        cyc(0, 0, 0, 0, 1);

        // Rounds 4..8 alternate mismatch/match
        play_round(1'b0, 4'd4, 4'd2, 4'd2);
        cyc(0, 0, 0, 0, 1);
        play_round(1'b1, 4'd5, 4'd2, 4'd3);
        cyc(0, 0, 0, 0, 1);
        play_round(1'b0, 4'd6, 4'd3, 4'd3);
        cyc(0, 0, 0, 0, 1);
        play_round(1'b1, 4'd7, 4'd3, 4'd4);
        cyc(0, 0, 0, 0, 1);
        play_round(1'b0, 4'd8, 4'd4, 4'd4);
        cyc(0, 0, 0, 0, 1);
        chk("go_game_over", 32'(bus.game_over), 32'd1);
        chk("go_round", 32'(bus.round), 32'd8);
        chk("go_p1_score", 32'(bus.p1_score), 32'd4);
        chk("go_p2_score", 32'(bus.p2_score), 32'd4);
        chk("go_valid", 32'(bus.result_valid), 32'd0);
        cyc(0, 1, 0, 0, 1);
        chk("go_hold_value", 32'(bus.p1_value), 32'h001);
        chk("go_hold", 32'(bus.game_over), 32'd1);
        cyc(1, 0, 0, 0, 0);
        chk("restart_round", 32'(bus.round), 32'd1);
        chk("restart_p1_score", 32'(bus.p1_score), 32'd0);
        chk("restart_p2_score", 32'(bus.p2_score), 32'd0);
        chk("restart_game_over", 32'(bus.game_over), 32'd0);
        chk("restart_value", 32'(bus.p1_value), 32'd0);

        // Reset mid-P2_ENTRY with start held
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk("pre_rst_p2_value", 32'(bus.p2_value), 32'h001);
        resetn = 1'b0;
        cyc(1, 0, 0, 0, 0);
        chk("rst2_round", 32'(bus.round), 32'd0);
        chk("rst2_p2_active", 32'(bus.p2_active), 32'd0);
        chk("rst2_p1_value", 32'(bus.p1_value), 32'd0);
        chk("rst2_p2_value", 32'(bus.p2_value), 32'd0);
        chk("rst2_count", 32'(bus.symbol_count), 32'd0);
        chk("rst2_clear", 32'(bus.decoder_clear), 32'd0);
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("rst2_still_idle", 32'(bus.p1_active), 32'd0);

        // Reset during RESULT
        cyc(1, 0, 0, 0, 0);
        play_round(1'b1, 4'd1, 4'd0, 4'd1);
        resetn = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("rst3_valid", 32'(bus.result_valid), 32'd0);
        chk("rst3_match", 32'(bus.match), 32'd0);
        chk("rst3_p2_score", 32'(bus.p2_score), 32'd0);
        chk("rst3_round", 32'(bus.round), 32'd0);
        resetn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
